uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10417, giving clk cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.

Ports (name  direction  width  meaning):
REQ-002 SHALL provide clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide transmit  input  1  debounced, clk-synchronous send request level from the upstream debouncer.
REQ-005 SHALL provide data  input  8  byte to send; sampled only at frame acceptance.
REQ-006 SHALL provide txd  output  1  serial line, idle high.
REQ-007 SHALL provide busy  output  1  high while a frame is in progress.
REQ-008 SHALL provide done  output  1  one-cycle pulse at frame completion.

Function
REQ-009 SHALL register transmit into transmit_q each cycle; a request is a rising edge: transmit=1 and transmit_q=0.
REQ-010 SHALL implement states IDLE, START, DATA, STOP.
REQ-011 In IDLE, on a request, SHALL latch data into an 8-bit shift register, clear the baud counter and bit index, and enter START; txd goes low on the next cycle (1-cycle latency).
REQ-012 SHALL hold each of START, each DATA bit and STOP for exactly CLKS_PER_BIT cycles, using a 16-bit baud counter from 0 to CLKS_PER_BIT-1 that clears on each bit boundary.
REQ-013 SHALL drive txd=0 in START, the latched bits LSB first in DATA (3-bit index 0..7, exit after index 7), and txd=1 in STOP and IDLE.
REQ-014 Frame SHALL be exactly 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-015 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-016 After the last STOP cycle SHALL return to IDLE and assert done for exactly that first IDLE cycle.
REQ-017 SHALL ignore requests while busy=1; they are not queued.
REQ-018 transmit_q SHALL keep tracking transmit while busy, so a level held high across frame end does not start a new frame.
REQ-019 A request in the same cycle that done=1 SHALL be accepted (back-to-back frames with no idle gap beyond that cycle).
REQ-020 Changes on data after acceptance SHALL NOT affect the frame in progress.
REQ-021 txd SHALL be driven from a register (glitch-free).

Reset
REQ-022 On reset assertion SHALL asynchronously force: state=IDLE, txd=1, busy=0, done=0, baud counter=0, bit index=0, shift register=0x00.
REQ-023 Reset SHALL force transmit_q=1, so a transmit level already high at reset release starts no frame.
REQ-024 Reset asserted mid-frame SHALL abort the frame with txd=1 immediately; no done pulse.

Verification (CLKS_PER_BIT=4)
REQ-025 The bench SHALL cover: data=0xA5 with one transmit pulse -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy high for 40 cycles; done=1 for 1 cycle after.
REQ-026 The bench SHALL cover: transmit held high for 200 cycles with data=0x3C -> exactly one frame; no second start bit.
REQ-027 The bench SHALL cover: second rising edge 10 cycles into a frame of 0x0F -> ignored; only the 0x0F frame is sent.
REQ-028 The bench SHALL cover: request on the done cycle with data=0x81 after a 0xFF frame -> the next START begins on the following cycle; the 0x81 bits are correct.
REQ-029 The bench SHALL cover: reset pulsed 15 cycles into a frame -> txd=1 and busy=0 asynchronously; no done; the next request sends a full correct frame.
REQ-030 The bench SHALL cover: transmit high during reset and after release -> txd stays 1 and busy stays 0 until transmit falls and rises again.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: 8N1 frames (start, 8 data bits LSB first, stop) launched
// on a rising edge of the transmit request level, with a one-cycle done pulse.
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transmit,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_nx;
    logic [15:0] baud_cnt, baud_nx;
    logic [2:0]  bit_idx, bit_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        txd_nx;
    logic        done_nx;
    logic        transmit_q;
    logic        request;
    logic        bit_end;

    assign request = transmit & ~transmit_q;
    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt + 16'd1;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        txd_nx   = txd;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                baud_nx = '0;
                txd_nx  = 1'b1;
                if (request) begin
                    shreg_nx = data;
                    bit_nx   = '0;
                    txd_nx   = 1'b0;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_nx  = '0;
                    txd_nx   = shreg[0];
                    state_nx = DATA;
                end
            end
            DATA: begin
                // shreg[0] is always the bit currently on the line
                if (bit_end) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        txd_nx   = 1'b1;
                        state_nx = STOP;
                    end else begin
                        bit_nx   = bit_idx + 3'd1;
                        shreg_nx = shreg >> 1;
                        txd_nx   = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_nx  = '0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                baud_nx  = '0;
                txd_nx   = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // transmit_q resets high so a level already asserted at release is not a request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            txd        <= 1'b1;
            done       <= 1'b0;
            transmit_q <= 1'b1;
        end else begin
            state      <= state_nx;
            baud_cnt   <= baud_nx;
            bit_idx    <= bit_nx;
            shreg      <= shreg_nx;
            txd        <= txd_nx;
            done       <= done_nx;
            transmit_q <= transmit;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer at CLKS_PER_BIT=4; inputs driven and outputs
// sampled on the falling clock edge.
module tb_uart_tx_framer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       transmit = 1'b0;
    logic [7:0] data = 8'h00;
    logic       txd;
    logic       busy;
    logic       done;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .transmit (transmit),
        .data     (data),
        .txd      (txd),
        .busy     (busy),
        .done     (done)
    );

    // bit 0 = first bit on the line
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    function automatic logic [39:0] expand(input logic [9:0] seq);
        logic [39:0] r;
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < CPB; c++)
                r[i*CPB + c] = seq[i];
        return r;
    endfunction

    // Samples 40 cycles starting the cycle after a request was driven, applying
    // scheduled input changes after the indexed sample.
    task automatic capture(input int drop_at, input int rise_at, input int chg_at,
                           input logic [7:0] chg_val, output logic [39:0] tx_bits,
                           output logic [39:0] busy_bits, output int done_seen);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            tx_bits[i]   = txd;
            busy_bits[i] = busy;
            if (done) done_seen++;
            if (i == drop_at) transmit = 1'b0;
            if (i == rise_at) transmit = 1'b1;
            if (rise_at >= 0 && i == rise_at + 1) transmit = 1'b0;
            if (i == chg_at) data = chg_val;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        transmit = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (txd !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset: txd=%b busy=%b expected 1/0", txd, busy); else passes++;
    endtask

    task automatic test_single_a5();
        logic [39:0] tb, bb;
        int ds;
        data = 8'hA5;
        transmit = 1'b1;
        // data changes mid-frame must not leak into the frame
        capture(0, -1, 5, 8'h00, tb, bb, ds);
        checks++; if (tb !== expand(10'b1101001010)) $display("FAIL a5_txd: got %h expected %h", tb, expand(10'b1101001010)); else passes++;
        checks++; if (bb !== {40{1'b1}}) $display("FAIL a5_busy: got %h expected %h", bb, {40{1'b1}}); else passes++;
        checks++; if (ds !== 0) $display("FAIL a5_done_early: got %0d expected 0", ds); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL a5_done: got %b expected 1", done); else passes++;
        checks++; if (busy !== 1'b0 || txd !== 1'b1) $display("FAIL a5_end_idle: busy=%b txd=%b expected 0/1", busy, txd); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL a5_done_width: got %b expected 0", done); else passes++;
    endtask

    task automatic test_held_level();
        logic [39:0] tb, bb;
        int ds, bad;
        data = 8'h3C;
        transmit = 1'b1;
        capture(-1, -1, -1, 8'h00, tb, bb, ds);
        checks++; if (tb !== expand(frame_of(8'h3C))) $display("FAIL held_txd: got %h expected %h", tb, expand(frame_of(8'h3C))); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL held_done: got %b expected 1", done); else passes++;
        bad = 0;
        for (int i = 0; i < 159; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL held_restart: got %0d active cycles expected 0", bad); else passes++;
        transmit = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        logic [39:0] tb, bb;
        int ds, bad;
        data = 8'h0F;
        transmit = 1'b1;
        capture(0, 9, 9, 8'hF0, tb, bb, ds);
        checks++; if (tb !== expand(frame_of(8'h0F))) $display("FAIL ignore_txd: got %h expected %h", tb, expand(frame_of(8'h0F))); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL ignore_done: got %b expected 1", done); else passes++;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL ignore_queued: got %0d active cycles expected 0", bad); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [39:0] tb, bb;
        int ds;
        data = 8'hFF;
        transmit = 1'b1;
        capture(0, -1, -1, 8'h00, tb, bb, ds);
        checks++; if (tb !== expand(frame_of(8'hFF))) $display("FAIL b2b_first_txd: got %h expected %h", tb, expand(frame_of(8'hFF))); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL b2b_done: got %b expected 1", done); else passes++;
        data = 8'h81;
        transmit = 1'b1;
        capture(0, -1, -1, 8'h00, tb, bb, ds);
        checks++; if (tb !== expand(frame_of(8'h81))) $display("FAIL b2b_second_txd: got %h expected %h", tb, expand(frame_of(8'h81))); else passes++;
        checks++; if (bb !== {40{1'b1}}) $display("FAIL b2b_busy: got %h expected %h", bb, {40{1'b1}}); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL b2b_second_done: got %b expected 1", done); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] tb, bb;
        int ds, dcount;
        data = 8'h55;
        transmit = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dcount++;
            if (i == 0) transmit = 1'b0;
        end
        checks++; if (busy !== 1'b1) $display("FAIL midreset_pre_busy: got %b expected 1", busy); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) $display("FAIL midreset_txd_async: got %b expected 1", txd); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midreset_busy_async: got %b expected 0", busy); else passes++;
        repeat (2) @(negedge clk);
        if (done) dcount++;
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checks++; if (dcount !== 0) $display("FAIL midreset_done: got %0d pulses expected 0", dcount); else passes++;
        data = 8'hC3;
        transmit = 1'b1;
        capture(0, -1, -1, 8'h00, tb, bb, ds);
        checks++; if (tb !== expand(frame_of(8'hC3))) $display("FAIL midreset_next_txd: got %h expected %h", tb, expand(frame_of(8'hC3))); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL midreset_next_done: got %b expected 1", done); else passes++;
    endtask

    task automatic test_high_through_reset();
        logic [39:0] tb, bb;
        int ds, bad;
        transmit = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL held_reset_start: got %0d active cycles expected 0", bad); else passes++;
        transmit = 1'b0;
        @(negedge clk);
        data = 8'h5A;
        transmit = 1'b1;
        capture(0, -1, -1, 8'h00, tb, bb, ds);
        checks++; if (tb !== expand(frame_of(8'h5A))) $display("FAIL held_reset_next_txd: got %h expected %h", tb, expand(frame_of(8'h5A))); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL held_reset_next_done: got %b expected 1", done); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_held_level();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_high_through_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
